// File: rtl/ps_kernel_scheduler.sv
// -----------------------------------------------------------------------------
// ps_kernel_scheduler
//
// Frame-level read scheduler for the 3x3 kernel line-buffer bank. Input line n
// lives in buffer (n mod NUM_BUFS). The block counts completed input lines,
// only lets upstream write while a free buffer exists, decides when each output
// row has all three source lines available, and then issues LINE_LENGTH read
// strobes under downstream backpressure.
//
// Ports
//   i_clk          clock
//   i_rstn         synchronous active-low reset
//   i_frame_start  pulse, arms a new frame (only honoured while idle)
//   i_line_done    pulse, one full input line has been written
//   o_wr_allow     upstream may write into the current write buffer
//   i_out_ready    downstream accepts a kernel column this cycle
//   o_rd_en        read strobe, one kernel column per assertion
//   o_rd_mask      per-buffer read enable for the top/mid/bot buffers
//   o_sel_top/mid/bot  buffer index of row above / current row / row below
//   o_sof/o_eof/o_sol/o_eol  frame/line sideband, qualified by o_rd_en
//   o_row          current output row
//   o_busy         scheduler is not idle
//   o_err          sticky protocol error (dropped line or late frame start)
// -----------------------------------------------------------------------------
module ps_kernel_scheduler #(
  parameter int LINE_LENGTH = 640,
  parameter int FRAME_LINES = 480,
  parameter int NUM_BUFS    = 4,
  parameter int SELW        = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_frame_start,
  input  logic                           i_line_done,
  output logic                           o_wr_allow,
  input  logic                           i_out_ready,
  output logic                           o_rd_en,
  output logic [NUM_BUFS-1:0]            o_rd_mask,
  output logic [SELW-1:0]                o_sel_top,
  output logic [SELW-1:0]                o_sel_mid,
  output logic [SELW-1:0]                o_sel_bot,
  output logic                           o_sof,
  output logic                           o_eof,
  output logic                           o_sol,
  output logic                           o_eol,
  output logic [$clog2(FRAME_LINES)-1:0] o_row,
  output logic                           o_busy,
  output logic                           o_err
);

  localparam int ROWW = $clog2(FRAME_LINES);
  localparam int COLW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  // The write counter has to reach FRAME_LINES itself, hence the +1.
  localparam int WCW  = $clog2(FRAME_LINES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Buffer holding a given line: NUM_BUFS is a power of two, so the modulo is
  // just the low SELW bits of the line number.
  function automatic logic [SELW-1:0] buf_of(input logic [ROWW:0] row);
    return SELW'(row);
  endfunction

  function automatic logic [NUM_BUFS-1:0] onehot(input logic [SELW-1:0] sel);
    return {{(NUM_BUFS-1){1'b0}}, 1'b1} << sel;
  endfunction

  state_t            state_r,       state_s;
  logic [WCW-1:0]    wr_line_cnt_r, wr_line_cnt_s;
  logic [ROWW-1:0]   rd_row_r,      rd_row_s;
  logic [COLW-1:0]   col_r,         col_s;
  logic              err_r,         err_s;
  logic [SELW-1:0]   sel_top_r, sel_mid_r, sel_bot_r;
  logic [SELW-1:0]   sel_top_s, sel_mid_s, sel_bot_s;
  logic              sel_upd_s;

  logic [31:0]       row_base_s;
  logic [31:0]       held_s;
  logic [31:0]       need_s;
  logic [31:0]       rd_plus2_s;
  logic              wr_allow_s;
  logic              strobe_s;
  logic              last_col_s;
  logic              last_row_s;
  logic              accept_line_s;
  logic              drop_line_s;
  logic [ROWW:0]     top_row_s;
  logic [ROWW:0]     bot_row_s;

  // Occupancy and readiness terms derived from the registered counters.
  always_comb begin
    // Row r still needs line r-1, so everything below that has been consumed.
    if (rd_row_r == {ROWW{1'b0}}) begin
      row_base_s = 32'd0;
    end else begin
      row_base_s = 32'(rd_row_r) - 32'd1;
    end
    held_s = 32'(wr_line_cnt_r) - row_base_s;

    // Row r can start once line r+1 exists; the last row only needs the last line.
    rd_plus2_s = 32'(rd_row_r) + 32'd2;
    if (rd_plus2_s > 32'(FRAME_LINES)) begin
      need_s = 32'(FRAME_LINES);
    end else begin
      need_s = rd_plus2_s;
    end

    wr_allow_s    = (state_r != ST_IDLE) &&
                    (32'(wr_line_cnt_r) < 32'(FRAME_LINES)) &&
                    (held_s < 32'(NUM_BUFS));
    strobe_s      = (state_r == ST_ACTIVE) && i_out_ready;
    last_col_s    = (col_r == COLW'(LINE_LENGTH - 1));
    last_row_s    = (rd_row_r == ROWW'(FRAME_LINES - 1));
    accept_line_s = i_line_done && wr_allow_s;
    drop_line_s   = i_line_done && !wr_allow_s;
  end

  // Next-state logic for the FSM and the frame counters.
  always_comb begin
    state_s   = state_r;
    rd_row_s  = rd_row_r;
    col_s     = col_r;
    sel_upd_s = 1'b0;

    // Line completion is independent of the read side, so it applies in the
    // same cycle as any row advance below.
    if (accept_line_s) begin
      wr_line_cnt_s = wr_line_cnt_r + WCW'(1);
    end else begin
      wr_line_cnt_s = wr_line_cnt_r;
    end

    if (drop_line_s || (i_frame_start && (state_r != ST_IDLE))) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (i_frame_start) begin
          state_s       = ST_WAIT;
          wr_line_cnt_s = {WCW{1'b0}};
          rd_row_s      = {ROWW{1'b0}};
          col_s         = {COLW{1'b0}};
          err_s         = 1'b0;
          sel_upd_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (32'(wr_line_cnt_r) >= need_s) begin
          state_s = ST_ACTIVE;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_ACTIVE: begin
        if (strobe_s) begin
          if (last_col_s) begin
            col_s = {COLW{1'b0}};
            if (last_row_s) begin
              state_s = ST_IDLE;
            end else begin
              rd_row_s  = rd_row_r + ROWW'(1);
              state_s   = ST_WAIT;
              sel_upd_s = 1'b1;
            end
          end else begin
            col_s = col_r + COLW'(1);
          end
        end else begin
          state_s = ST_ACTIVE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Buffer selects for the row being entered, with top/bottom replication.
  always_comb begin
    if (rd_row_s == {ROWW{1'b0}}) begin
      top_row_s = {(ROWW+1){1'b0}};
    end else begin
      top_row_s = {1'b0, rd_row_s} - (ROWW+1)'(1);
    end
    if (rd_row_s == ROWW'(FRAME_LINES - 1)) begin
      bot_row_s = {1'b0, rd_row_s};
    end else begin
      bot_row_s = {1'b0, rd_row_s} + (ROWW+1)'(1);
    end
    sel_top_s = buf_of(top_row_s);
    sel_mid_s = buf_of({1'b0, rd_row_s});
    sel_bot_s = buf_of(bot_row_s);
  end

  // FSM state and counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r       <= ST_IDLE;
      wr_line_cnt_r <= {WCW{1'b0}};
      rd_row_r      <= {ROWW{1'b0}};
      col_r         <= {COLW{1'b0}};
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      wr_line_cnt_r <= wr_line_cnt_s;
      rd_row_r      <= rd_row_s;
      col_r         <= col_s;
      err_r         <= err_s;
    end
  end

  // Select registers; they only move when the row changes so they stay zero
  // from reset until the first frame is armed.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sel_top_r <= {SELW{1'b0}};
      sel_mid_r <= {SELW{1'b0}};
      sel_bot_r <= {SELW{1'b0}};
    end else if (sel_upd_s) begin
      sel_top_r <= sel_top_s;
      sel_mid_r <= sel_mid_s;
      sel_bot_r <= sel_bot_s;
    end else begin
      sel_top_r <= sel_top_r;
      sel_mid_r <= sel_mid_r;
      sel_bot_r <= sel_bot_r;
    end
  end

  // Output drive: strobe follows i_out_ready directly, sideband gated by it.
  always_comb begin
    o_rd_en    = strobe_s;
    o_wr_allow = wr_allow_s;
    o_sel_top  = sel_top_r;
    o_sel_mid  = sel_mid_r;
    o_sel_bot  = sel_bot_r;
    o_row      = rd_row_r;
    o_busy     = (state_r != ST_IDLE);
    o_err      = err_r;
    if (strobe_s) begin
      // Border rows select one buffer twice, leaving only two mask bits set.
      o_rd_mask = onehot(sel_top_r) | onehot(sel_mid_r) | onehot(sel_bot_r);
      o_sol     = (col_r == {COLW{1'b0}});
      o_eol     = last_col_s;
      o_sof     = (rd_row_r == {ROWW{1'b0}}) && (col_r == {COLW{1'b0}});
      o_eof     = last_row_s && last_col_s;
    end else begin
      o_rd_mask = {NUM_BUFS{1'b0}};
      o_sol     = 1'b0;
      o_eol     = 1'b0;
      o_sof     = 1'b0;
      o_eof     = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps_kernel_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for ps_kernel_scheduler (LINE_LENGTH=8, FRAME_LINES=6, NUM_BUFS=4).
// Per-row select/mask vectors come from a constant table; each armed frame
// pushes its 48 expected strobe records to a queue that is popped as the DUT
// strobes. Hand-written sequences cover overrun, simultaneous line/row
// completion, late frame start and reset in the middle of a row.
// -----------------------------------------------------------------------------
module tb_ps_kernel_scheduler;

  localparam int LL = 8;
  localparam int FL = 6;
  localparam int NB = 4;
  localparam int SW = 2;
  localparam int RW = $clog2(FL);

  logic          clk = 1'b0;
  logic          rstn;
  logic          frame_start;
  logic          line_done;
  logic          out_ready;
  logic          wr_allow;
  logic          rd_en;
  logic [NB-1:0] rd_mask;
  logic [SW-1:0] sel_top, sel_mid, sel_bot;
  logic          sof, eof, sol, eol;
  logic [RW-1:0] row;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  ps_kernel_scheduler #(
    .LINE_LENGTH(LL), .FRAME_LINES(FL), .NUM_BUFS(NB), .SELW(SW)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_frame_start(frame_start),
    .i_line_done(line_done), .o_wr_allow(wr_allow), .i_out_ready(out_ready),
    .o_rd_en(rd_en), .o_rd_mask(rd_mask), .o_sel_top(sel_top),
    .o_sel_mid(sel_mid), .o_sel_bot(sel_bot), .o_sof(sof), .o_eof(eof),
    .o_sol(sol), .o_eol(eol), .o_row(row), .o_busy(busy), .o_err(err)
  );

  typedef struct packed {
    logic [RW-1:0] row;
    logic [SW-1:0] top;
    logic [SW-1:0] mid;
    logic [SW-1:0] bot;
    logic [NB-1:0] mask;
    logic          sof;
    logic          eof;
    logic          sol;
    logic          eol;
  } strobe_t;

  typedef struct {
    int            row;
    logic [SW-1:0] top;
    logic [SW-1:0] mid;
    logic [SW-1:0] bot;
    logic [NB-1:0] mask;
  } row_vec_t;

  row_vec_t tbl [FL];
  strobe_t  exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int n_strobe, n_sof, n_eof, n_sol, n_eol;
  int first_strobe_cyc;
  int ld2_cyc;
  int lines_sent;
  bit mon_en   = 1'b0;
  bit chk_zero = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    strobe_t act;
    strobe_t e;
    if (chk_zero) begin
      chk("post_reset_outputs",
          32'({rd_en, rd_mask, sel_top, sel_mid, sel_bot, sof, eof, sol, eol,
               row, busy, wr_allow, err}), 32'd0);
    end
    if (rd_en === 1'b1) begin
      chk("rd_en_needs_ready", 32'(out_ready), 32'd1);
      act = {row, sel_top, sel_mid, sel_bot, rd_mask, sof, eof, sol, eol};
      n_strobe++;
      if (sof) n_sof++;
      if (eof) n_eof++;
      if (sol) n_sol++;
      if (eol) n_eol++;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc_no;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got 0x%0h expected no strobe", act);
      end else begin
        e = exp_q.pop_front();
        chk("strobe", 32'(act), 32'(e));
      end
    end else begin
      chk("idle_sideband", 32'({rd_mask, sof, eof, sol, eol}), 32'd0);
    end
  endtask

  // One clock cycle: inputs already set, sample at the falling edge, then
  // return 1 time unit after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic push_frame();
    strobe_t e;
    for (int r = 0; r < FL; r++) begin
      for (int c = 0; c < LL; c++) begin
        e.row  = RW'(tbl[r].row);
        e.top  = tbl[r].top;
        e.mid  = tbl[r].mid;
        e.bot  = tbl[r].bot;
        e.mask = tbl[r].mask;
        e.sof  = (r == 0) && (c == 0);
        e.eof  = (r == FL-1) && (c == LL-1);
        e.sol  = (c == 0);
        e.eol  = (c == LL-1);
        exp_q.push_back(e);
      end
    end
    n_strobe = 0; n_sof = 0; n_eof = 0; n_sol = 0; n_eol = 0;
    first_strobe_cyc = -1;
    ld2_cyc = -100;
  endtask

  task automatic arm_frame();
    push_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  // Feeds remaining lines (every 'spacing' cycles, or as soon as allowed when
  // spacing==1) until the frame is complete; bp toggles ready during row 2.
  task automatic finish_frame(input int spacing, input bit bp, input int budget);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < budget) begin
      if (spacing > 1) line_done = (lines_sent < FL) && (t % spacing == 0);
      else             line_done = (lines_sent < FL) && wr_allow;
      out_ready = (bp && row == 2) ? cyc_no[0] : 1'b1;
      cyc();
      if (line_done) begin
        lines_sent++;
        if (lines_sent == 2) ld2_cyc = cyc_no - 1;
      end
      t++;
      done = (lines_sent == FL) && !busy;
    end
    line_done = 1'b0;
    out_ready = 1'b1;
    chk("frame_complete_idle", 32'(busy), 32'd0);
  endtask

  task automatic end_frame_checks();
    chk("strobe_count", 32'(n_strobe), 32'(FL*LL));
    chk("sof_count", 32'(n_sof), 32'd1);
    chk("eof_count", 32'(n_eof), 32'd1);
    chk("sol_count", 32'(n_sol), 32'(FL));
    chk("eol_count", 32'(n_eol), 32'(FL));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit found;
    //           row top    mid    bot    mask
    tbl[0] = '{0, 2'd0, 2'd0, 2'd1, 4'b0011};
    tbl[1] = '{1, 2'd0, 2'd1, 2'd2, 4'b0111};
    tbl[2] = '{2, 2'd1, 2'd2, 2'd3, 4'b1110};
    tbl[3] = '{3, 2'd2, 2'd3, 2'd0, 4'b1101};
    tbl[4] = '{4, 2'd3, 2'd0, 2'd1, 4'b1011};
    tbl[5] = '{5, 2'd0, 2'd1, 2'd1, 4'b0011};

    rstn = 1'b0; frame_start = 1'b0; line_done = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    mon_en = 1'b1;
    chk_zero = 1'b1; cyc(); chk_zero = 1'b0;
    rstn = 1'b1;
    cyc();

    // Basic frame, lines every 10 cycles, always ready.
    arm_frame();
    lines_sent = 0;
    finish_frame(10, 1'b0, 400);
    chk("row0_latency", 32'(first_strobe_cyc - ld2_cyc), 32'd2);
    end_frame_checks();
    chk("basic_err", 32'(err), 32'd0);

    // Backpressure: ready toggles every cycle while row 2 is current.
    arm_frame();
    lines_sent = 0;
    finish_frame(12, 1'b1, 500);
    end_frame_checks();
    chk("bp_err", 32'(err), 32'd0);

    // Overrun: four lines with nothing drained fill the bank.
    out_ready = 1'b0;
    arm_frame();
    line_done = 1'b1;
    repeat (3) cyc();
    chk("wr_allow_after_3", 32'(wr_allow), 32'd1);
    cyc();
    line_done = 1'b0;
    chk("wr_allow_after_4", 32'(wr_allow), 32'd0);
    chk("err_before_drop", 32'(err), 32'd0);
    line_done = 1'b1;
    cyc();
    line_done = 1'b0;
    chk("err_after_drop", 32'(err), 32'd1);
    chk("wr_cnt_after_drop", 32'(dut.wr_line_cnt_r), 32'd4);
    lines_sent = 4;
    finish_frame(1, 1'b0, 400);
    end_frame_checks();
    chk("err_sticky", 32'(err), 32'd1);

    // Line completion on the same cycle as row 1's final strobe.
    out_ready = 1'b1;
    arm_frame();
    line_done = 1'b1;
    repeat (3) cyc();
    line_done = 1'b0;
    lines_sent = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      line_done = rd_en && eol && (row == 1);
      found = line_done;
      cyc();
    end
    line_done = 1'b0;
    chk("sim_found", 32'(found), 32'd1);
    chk("sim_row", 32'(row), 32'd2);
    chk("sim_wr_cnt", 32'(dut.wr_line_cnt_r), 32'd4);
    chk("sim_wr_allow", 32'(wr_allow), 32'd1);
    chk("sim_err", 32'(err), 32'd0);
    lines_sent = 4;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk("late_start_err", 32'(err), 32'd1);
    chk("late_start_busy", 32'(busy), 32'd1);
    finish_frame(1, 1'b0, 400);
    end_frame_checks();

    // Reset at row 2, column 3, then a fresh frame.
    arm_frame();
    lines_sent = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (rd_en && (row == 2) && sol) begin
        found = 1'b1;
      end else begin
        line_done = (lines_sent < FL) && wr_allow;
        cyc();
        if (line_done) lines_sent++;
        line_done = 1'b0;
      end
    end
    chk("reset_point_found", 32'(found), 32'd1);
    repeat (3) cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk_zero = 1'b1; cyc(); chk_zero = 1'b0;
    exp_q.delete();
    arm_frame();
    lines_sent = 0;
    finish_frame(1, 1'b0, 400);
    end_frame_checks();
    chk("post_reset_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
